// File: rtl/muldiv_unit_if.sv
// Issue/result handshake bundle for the iterative multiply/divide unit.
// The pipeline side is the master; the execution unit is the slave.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_addr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      out_rd_addr;
    logic            busy;

    modport master (
        output in_valid, op, operand_a, operand_b, rd_addr,
        output flush, out_ready,
        input  in_ready, out_valid, result, out_rd_addr, busy
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, rd_addr,
        input  flush, out_ready,
        output in_ready, out_valid, result, out_rd_addr, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: one bit per cycle on magnitudes,
// sign fix-up in a final cycle, result held until writeback takes it.
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_sa;
    logic                r_sb;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic                r_special;
    logic [XLEN-1:0]     r_spec_res;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_out_rd;
    logic                r_out_valid;

    logic                w_a_sgn_op;
    logic                w_b_sgn_op;
    logic                w_sa;
    logic                w_sb;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [XLEN-1:0]     w_spec_res;

    logic [XLEN-1:0]     w_hi;
    logic [XLEN-1:0]     w_lo;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_rsh;
    logic                w_ge;
    logic [XLEN-1:0]     w_dif;
    logic [XLEN-1:0]     w_rem_nx;
    logic [2*XLEN-1:0]   w_mul_nx;
    logic [2*XLEN-1:0]   w_div_nx;

    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    // Operand decode: which operands are signed and the RISC-V special cases
    assign w_a_sgn_op = (bus.op == 3'd1) || (bus.op == 3'd2) ||
                        (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_b_sgn_op = (bus.op == 3'd1) || (bus.op == 3'd4) ||
                        (bus.op == 3'd6);
    assign w_sa       = w_a_sgn_op && bus.operand_a[XLEN-1];
    assign w_sb       = w_b_sgn_op && bus.operand_b[XLEN-1];
    assign w_abs_a    = w_sa ? -bus.operand_a : bus.operand_a;
    assign w_abs_b    = w_sb ? -bus.operand_b : bus.operand_b;
    assign w_b_zero   = (bus.operand_b == '0);
    assign w_ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                        (bus.operand_a == MIN_NEG) &&
                        (bus.operand_b == '1);
    assign w_special  = bus.op[2] && (w_b_zero || w_ovf);
    assign w_spec_res = w_b_zero ? (bus.op[1] ? bus.operand_a : '1)
                                 : (bus.op[1] ? '0 : bus.operand_a);

    // One iteration step: shift-add multiply / restoring divide
    assign w_hi     = r_acc[2*XLEN-1:XLEN];
    assign w_lo     = r_acc[XLEN-1:0];
    assign w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nx = {w_sum, w_lo[XLEN-1:1]};
    assign w_rsh    = {w_hi, w_lo[XLEN-1]};
    assign w_ge     = (w_rsh >= {1'b0, r_opnd});
    assign w_dif    = w_rsh[XLEN-1:0] - r_opnd;
    assign w_rem_nx = w_ge ? w_dif : w_rsh[XLEN-1:0];
    assign w_div_nx = {w_rem_nx, w_lo[XLEN-2:0], w_ge};

    // Sign correction and half selection applied in FIX
    assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo     = (r_sa ^ r_sb) ? -w_lo : w_lo;
    assign w_rem     = r_sa ? -w_hi : w_hi;
    assign w_fix_res = r_special ? r_spec_res :
                       r_op[2]   ? (r_op[1] ? w_rem : w_quo) :
                       (r_op == 3'd0) ? w_prod[XLEN-1:0]
                                      : w_prod[2*XLEN-1:XLEN];

    // Control FSM with registered datapath and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_special   <= 1'b0;
            r_spec_res  <= '0;
            r_rd        <= '0;
            r_result    <= '0;
            r_out_rd    <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.op;
                        r_sa       <= w_sa;
                        r_sb       <= w_sb;
                        r_rd       <= bus.rd_addr;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_cnt      <= CNT_W'(XLEN - 1);
                        if (bus.op[2]) begin
                            r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                        r_state <= (EARLY_OUT && w_special) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_nx : w_mul_nx;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    r_result    <= w_fix_res;
                    r_out_rd    <= r_rd;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE) && reset_n;
    assign bus.busy        = (r_state != IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.out_rd_addr = r_out_rd;
endmodule
